// File: rtl/viterbi_tbu.sv
// Traceback unit for a K=3, 4-state Viterbi decoder.
// Keeps the last TB_DEPTH survivor decision vectors in a circular buffer and
// runs one sequential traceback per accepted symbol once the window is full.
// Optional flush/drain support: define VITERBI_TBU_FLUSH_EN.
module viterbi_tbu #(
  parameter int unsigned TB_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [3:0] dec_bits_i,
  input  logic [1:0] best_state_i,
  output logic       bit_o,
  output logic       bit_valid_o,
  output logic       busy_o
`ifdef VITERBI_TBU_FLUSH_EN
  ,
  input  logic       flush_i,
  output logic       flush_done_o
`endif
);

  localparam int unsigned AW = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
  localparam int unsigned CW = $clog2(TB_DEPTH) + 1;
  localparam logic [AW-1:0] PTR_MAX    = AW'(TB_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(TB_DEPTH);
  localparam logic [CW-1:0] STEPS_INIT = CW'(TB_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, TRACE, OUT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    tb_mem [TB_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] fill_q, fill_d, fill_inc, steps_q, steps_d;
  logic [1:0]    tst_q, tst_d;
  logic [3:0]    dec_rd;
  logic          wr_en;
  logic          bit_q, bit_valid_q, busy_q;
`ifdef VITERBI_TBU_FLUSH_EN
  logic [AW-1:0] newest_q, newest_d;
  logic [1:0]    best_q, best_d;
  logic          flushing_q, flushing_d;
  logic [CW-1:0] rem_q, rem_d, pend;
  logic          done_q, done_d;
`endif

  assign ready_o     = (state_q == IDLE);
  assign bit_o       = bit_q;
  assign bit_valid_o = bit_valid_q;
  assign busy_o      = busy_q;
  assign dec_rd      = tb_mem[rd_q];
  assign fill_inc    = (fill_q == DEPTH_C) ? fill_q : fill_q + CW'(1);
`ifdef VITERBI_TBU_FLUSH_EN
  assign flush_done_o = done_q;
  // Bits still owed on a flush: the window minus the one already emitted.
  assign pend = (fill_q == DEPTH_C) ? STEPS_INIT : fill_q;
`endif

  // Survivor buffer write port; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) tb_mem[wr_q] <= dec_bits_i;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    fill_d  = fill_q;
    steps_d = steps_q;
    tst_d   = tst_q;
    wr_en   = 1'b0;
`ifdef VITERBI_TBU_FLUSH_EN
    newest_d   = newest_q;
    best_d     = best_q;
    flushing_d = flushing_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef VITERBI_TBU_FLUSH_EN
        if (flush_i) begin
          if (pend == '0) begin
            done_d = 1'b1;
            fill_d = '0;
            wr_d   = '0;
          end else begin
            flushing_d = 1'b1;
            rem_d      = pend;
            tst_d      = best_q;
            rd_d       = newest_q;
            steps_d    = pend - CW'(1);
            state_d    = (pend == CW'(1)) ? OUT : TRACE;
          end
        end else
`endif
        if (valid_i && !rst_i) begin
          wr_en  = 1'b1;
          wr_d   = (wr_q == PTR_MAX) ? '0 : wr_q + AW'(1);
          tst_d  = best_state_i;
          fill_d = fill_inc;
`ifdef VITERBI_TBU_FLUSH_EN
          newest_d = wr_q;
          best_d   = best_state_i;
`endif
          if (fill_inc == DEPTH_C) begin
            state_d = TRACE;
            rd_d    = wr_q;
            steps_d = STEPS_INIT;
          end
        end
      end
      TRACE: begin
        tst_d   = {tst_q[0], dec_rd[tst_q]};
        rd_d    = (rd_q == '0) ? PTR_MAX : rd_q - AW'(1);
        steps_d = steps_q - CW'(1);
        if (steps_q == CW'(1)) state_d = OUT;
      end
      OUT: begin
        state_d = IDLE;
`ifdef VITERBI_TBU_FLUSH_EN
        if (flushing_q) begin
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            flushing_d = 1'b0;
            done_d     = 1'b1;
            fill_d     = '0;
            wr_d       = '0;
          end else begin
            tst_d   = best_q;
            rd_d    = newest_q;
            steps_d = rem_q - CW'(2);
            state_d = (rem_q == CW'(2)) ? OUT : TRACE;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      fill_q      <= '0;
      steps_q     <= '0;
      tst_q       <= '0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef VITERBI_TBU_FLUSH_EN
      newest_q   <= '0;
      best_q     <= '0;
      flushing_q <= 1'b0;
      rem_q      <= '0;
      done_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      fill_q      <= fill_d;
      steps_q     <= steps_d;
      tst_q       <= tst_d;
      bit_valid_q <= (state_d == OUT);
      busy_q      <= (state_d != IDLE);
      if (state_d == OUT) bit_q <= tst_d[1];
`ifdef VITERBI_TBU_FLUSH_EN
      newest_q   <= newest_d;
      best_q     <= best_d;
      flushing_q <= flushing_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
`endif
    end
  end

endmodule

// File: doc/viterbi_tbu.md
Name: viterbi_tbu

Overview:
- Traceback unit for the K=3, 4-state Viterbi decoder.
- Sits directly downstream of the ACSU and consumes its per-symbol 4-bit survivor decisions plus the index of the current best-metric state.
- Stores the last TB_DEPTH decision vectors in a circular buffer and runs a sequential traceback per accepted symbol.
- Emits one decoded bit per traceback, TB_DEPTH-1 symbols behind the newest input.

Parameters:
- TB_DEPTH, 16, traceback window length in symbols; legal range 2..64. Buffer depth = TB_DEPTH, pointer/counter width = clog2(TB_DEPTH)+1.

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  upstream symbol valid
- ready_o  out  1  unit can accept a symbol this cycle
- dec_bits_i  in  4  ACSU decisions; bit s = winning predecessor select for state s (0 = lower predecessor, 1 = upper)
- best_state_i  in  2  index of the minimum path metric state for this symbol
- bit_o  out  1  decoded bit
- bit_valid_o  out  1  one-cycle strobe qualifying bit_o
- busy_o  out  1  high while in TRACE or OUT

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state:
  - state=IDLE, wr_ptr=0, fill=0.
  - ready_o=1 (combinational from IDLE, so it reads 1 from the first cycle after reset), bit_o=0, bit_valid_o=0, busy_o=0.
  - Buffer contents need not be cleared.
- Trellis rules (fixed):
  - Next state = {u, s[1]}.
  - Predecessor of state s given decision d = {s[0], d}.
  - Decoded bit of a state = s[1].
- Accept: valid_i && ready_o at a rising edge.
  - Write dec_bits_i at wr_ptr; record newest pointer; wr_ptr increments mod TB_DEPTH.
  - Latch best_state_i into trace register tst.
  - fill = min(fill+1, TB_DEPTH).
- valid_i while ready_o=0 is ignored; upstream holds data until accepted.
- FSM states: IDLE, TRACE, OUT.
  - IDLE: ready_o=1. On accept, if the updated fill == TB_DEPTH, go to TRACE with rd_ptr=newest and steps=TB_DEPTH-1; otherwise stay in IDLE with no output. The first TB_DEPTH-1 symbols produce no bits.
  - TRACE: ready_o=0, busy_o=1. Each cycle: tst <= {tst[0], buf[rd_ptr][tst]}; rd_ptr decrements mod TB_DEPTH (wraps 0 -> TB_DEPTH-1); steps decrements. When steps reaches 1 on this cycle, go to OUT.
  - OUT: bit_o <= tst[1], bit_valid_o=1 for exactly this cycle, ready_o=0, then go to IDLE. bit_o holds its value until the next OUT.
- Latency: accept at edge k; TRACE occupies cycles k+1..k+TB_DEPTH-1; bit_valid_o is high in cycle k+TB_DEPTH; ready_o returns high in cycle k+TB_DEPTH+1. Throughput is one symbol per TB_DEPTH+1 cycles.
- Output ordering: one bit per accepted symbol once full, oldest first. Each output bit corresponds to symbol n-(TB_DEPTH-1).
- Wrap-around: the buffer overwrites the oldest entry once full; fill saturates and never rolls over.
- Reset mid-operation: rst_i in TRACE or OUT aborts immediately. No bit_valid_o is issued in the following cycle; all state returns to reset values.

Optional Feature:
- Macro: VITERBI_TBU_FLUSH_EN.
- When defined, adds ports flush_i (in, 1) and flush_done_o (out, 1, one-cycle strobe).
  - flush_i is sampled only in IDLE and has priority over valid_i in the same cycle (the symbol is not accepted).
  - On flush, drain the pending bits: P = min(fill, TB_DEPTH-1) bits, for symbols newest-P+1..newest, oldest first. Each uses a fresh traceback from the last latched best state with j = P-1 down to 0 steps (j=0 goes straight to OUT).
  - flush_done_o pulses in the cycle after the last OUT. fill and wr_ptr then reset to 0.
  - flush with fill=0 pulses flush_done_o the next cycle with no bits.
- When undefined, neither port exists; behaviour is as above.

Test Plan:
- Reset check: assert rst_i 2 cycles -> ready_o=1, bit_valid_o=0, busy_o=0, bit_o=0.
- Fill gating, TB_DEPTH=4: feed 3 symbols -> no bit_valid_o. 4th symbol accepted at edge k -> busy_o high in k+1..k+4, bit_valid_o only in cycle k+4, ready_o high again in k+5.
- Traceback correctness, TB_DEPTH=4:
  - dec_bits=4'b1111 all symbols, best_state=2'b11 -> path 3->3->3->3, bit_o=1.
  - dec_bits=4'b0000, best_state=2'b11 -> path 3->2->0->0, bit_o=0.
  - dec_bits=4'b1111, best_state=2'b10 -> path 2->1->3->3, bit_o=1.
- Wrap-around: stream 20 symbols from a golden encoder+ACSU model (TB_DEPTH=4, noiseless) -> 17 bit_valid_o strobes matching encoder input bits 0..16 in order.
- Backpressure and reset: hold valid_i high during TRACE -> no extra accept, exactly one bit per symbol. Assert rst_i in the 2nd TRACE cycle -> no bit_valid_o afterwards, ready_o=1 next cycle.
- Flush (VITERBI_TBU_FLUSH_EN, TB_DEPTH=4): 6 symbols then flush_i -> 3 further bits matching encoder inputs 3,4,5, then flush_done_o pulse. Next 3 symbols produce no output.
